// File: rtl/truth_table_sequencer_if.sv
// Bus between the truth-table sequencer and its host/function datapath.
// The master drives start/abort/f_in; the slave (sequencer) drives the rest.
interface truth_table_sequencer_if #(
  parameter int N = 4
) ();
  logic               start;
  logic               abort;
  logic               f_in;
  logic [N-1:0]       abcd;
  logic               busy;
  logic               done;
  logic [(2**N)-1:0]  table_out;
  logic [N:0]         ones_count;

  modport master (
    output start, abort, f_in,
    input  abcd, busy, done, table_out, ones_count
  );

  modport slave (
    input  start, abort, f_in,
    output abcd, busy, done, table_out, ones_count
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps an external N-input combinational function through all 2^N inputs,
// holding each for SETTLE+1 cycles and capturing the output into a truth table.
module truth_table_sequencer #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  truth_table_sequencer_if.slave  bus
);

  localparam int WCW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WCW-1:0] SETTLE_W = WCW'(SETTLE);
  localparam logic [N-1:0]   LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [N-1:0]        idx_q;
  logic [WCW-1:0]      wcnt_q;
  logic                busy_q;
  logic                done_q;
  logic [(2**N)-1:0]   table_q;
  logic [N:0]          ones_q;
  logic [N:0]          ones_d;

  always_comb begin
    ones_d = ones_q + (N+1)'(bus.f_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      ones_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            wcnt_q  <= '0;
            table_q <= '0;
            ones_q  <= '0;
          end
        end

        S_RUN: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            table_q <= '0;
            ones_q  <= '0;
          end else if (wcnt_q != SETTLE_W) begin
            // wcnt never exceeds SETTLE, so != is the same test as <
            wcnt_q <= wcnt_q + 1'b1;
          end else begin
            table_q[idx_q] <= bus.f_in;
            ones_q         <= ones_d;
            wcnt_q         <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          wcnt_q  <= '0;
        end
      endcase
    end
  end

  assign bus.abcd       = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.table_out  = table_q;
  assign bus.ones_count = ones_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: one instance with SETTLE=1 and
// one with SETTLE=0, each driven by a bench-side model of the function block.
module tb_truth_table_sequencer;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic sel;        // 0 = SETTLE=1 instance, 1 = SETTLE=0 instance
  int   mode;       // 0: f=0, 1: f=1, 2: f=ab~cd|~abcd|a~bcd|a~bc, 3: parity
  int   checks;
  int   errors;

  truth_table_sequencer_if #(.N(4)) bus_a ();
  truth_table_sequencer_if #(.N(4)) bus_b ();

  truth_table_sequencer #(.N(4), .SETTLE(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  truth_table_sequencer #(.N(4), .SETTLE(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  function automatic logic fmodel(input int m, input logic [3:0] x);
    logic a, b, c, d;
    {a, b, c, d} = x;
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (a & b & ~c & d) | (~a & b & c & d) | (a & ~b & c & d) | (a & ~b & c);
      default: return a ^ b ^ c ^ d;
    endcase
  endfunction

  assign bus_a.f_in  = fmodel(mode, bus_a.abcd);
  assign bus_b.f_in  = fmodel(mode, bus_b.abcd);
  assign bus_a.start = (sel == 1'b0) ? start : 1'b0;
  assign bus_b.start = (sel == 1'b1) ? start : 1'b0;
  assign bus_a.abort = (sel == 1'b0) ? abort : 1'b0;
  assign bus_b.abort = (sel == 1'b1) ? abort : 1'b0;

  logic [3:0]  o_abcd;
  logic        o_busy, o_done;
  logic [15:0] o_table;
  logic [4:0]  o_ones;

  always_comb begin
    o_abcd  = sel ? bus_b.abcd       : bus_a.abcd;
    o_busy  = sel ? bus_b.busy       : bus_a.busy;
    o_done  = sel ? bus_b.done       : bus_a.done;
    o_table = sel ? bus_b.table_out  : bus_a.table_out;
    o_ones  = sel ? bus_b.ones_count : bus_a.ones_count;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] et, input logic [4:0] eo);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
    chk({tag, "_done"},  32'(o_done),  32'd0);
    chk({tag, "_abcd"},  32'(o_abcd),  32'd0);
    chk({tag, "_table"}, 32'(o_table), 32'(et));
    chk({tag, "_ones"},  32'(o_ones),  32'(eo));
  endtask

  // Start on the next edge and follow the sweep through its done pulse.
  // len = 16*(SETTLE+1); abcd after k edges of RUN is k/(SETTLE+1).
  task automatic sweep(input string tag, input logic [15:0] et, input logic [4:0] eo,
                       input int len, input bit mid, input bit hold);
    int div;
    div = len / 16;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    chk({tag, "_busy0"}, 32'(o_busy), 32'd1);
    chk({tag, "_done0"}, 32'(o_done), 32'd0);
    for (int k = 1; k < len; k++) begin
      if (mid && k == 10) start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      chk({tag, "_busy"}, 32'(o_busy), 32'd1);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
      chk({tag, "_abcd"}, 32'(o_abcd), 32'(k / div));
    end
    tick();
    chk({tag, "_donepulse"}, 32'(o_done),  32'd1);
    chk({tag, "_busyend"},   32'(o_busy),  32'd0);
    chk({tag, "_abcdend"},   32'(o_abcd),  32'd15);
    chk({tag, "_table"},     32'(o_table), 32'(et));
    chk({tag, "_ones"},      32'(o_ones),  32'(eo));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    sel    = 1'b0;
    mode   = 2;
    #2;
    chk_idle("reset_a", 16'h0000, 5'd0);
    sel = 1'b1;
    #0;
    chk_idle("reset_b", 16'h0000, 5'd0);
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk_idle("idle_no_start", 16'h0000, 5'd0);

    // Main function, SETTLE=1
    mode = 2;
    sweep("func", 16'h2C80, 5'd4, 32, 1'b0, 1'b0);
    tick();
    chk_idle("func_after", 16'h2C80, 5'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort_in_idle", 16'h2C80, 5'd4);

    // Constant functions
    mode = 0;
    sweep("zero", 16'h0000, 5'd0, 32, 1'b0, 1'b0);
    tick();
    chk_idle("zero_after", 16'h0000, 5'd0);
    mode = 1;
    sweep("one", 16'hFFFF, 5'd16, 32, 1'b0, 1'b0);
    tick();
    chk_idle("one_after", 16'hFFFF, 5'd16);

    // Mid-sweep start pulse is ignored
    mode = 2;
    sweep("midstart", 16'h2C80, 5'd4, 32, 1'b1, 1'b0);
    tick();
    chk_idle("midstart_after", 16'h2C80, 5'd4);

    // Start held high: DONE, one IDLE cycle, then the next sweep
    mode = 3;
    sweep("hold1", 16'h6996, 5'd8, 32, 1'b0, 1'b1);
    tick();
    chk_idle("hold_gap", 16'h6996, 5'd8);
    mode = 2;
    sweep("hold2", 16'h2C80, 5'd4, 32, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    chk_idle("hold_after", 16'h2C80, 5'd4);

    // Abort while abcd=5 with f=1 so partial table is non-zero
    mode  = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    chk("abort_pre_abcd",  32'(o_abcd),  32'd5);
    chk("abort_pre_table", 32'(o_table), 32'h001F);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort", 16'h0000, 5'd0);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("abort_no_done", 32'(o_done), 32'd0);
    end
    mode = 2;
    sweep("post_abort", 16'h2C80, 5'd4, 32, 1'b0, 1'b0);
    tick();

    // Asynchronous reset between edges, mid-sweep
    mode  = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    chk("areset_pre_busy", 32'(o_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("areset", 16'h0000, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_idle("areset_idle", 16'h0000, 5'd0);
    end

    // SETTLE=0 instance, parity
    sel  = 1'b1;
    mode = 3;
    #0;
    chk_idle("b_idle", 16'h0000, 5'd0);
    sweep("parity", 16'h6996, 5'd8, 16, 1'b0, 1'b0);
    tick();
    chk_idle("parity_after", 16'h6996, 5'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete (checks %0d)", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
